// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the framed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;

  // Saturate a requested data-field length into [MIN_DATA_BITS, max_bits].
  function automatic logic [3:0] clamp_bits(input logic [3:0] req,
                                            input logic [3:0] max_bits);
    if (req < MIN_DATA_BITS) return MIN_DATA_BITS;
    if (req > max_bits)      return max_bits;
    return req;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: power-of-two depth, extra pointer bit distinguishes full from empty.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: FIFO-fed, per-frame latched divisor/length/parity/stop config.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_BITS   = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [MAX_BITS-1:0] writedata,
  input  logic                enable,
  output logic                ready,
  input  logic [DIV_W-1:0]    divisor,
  input  logic [3:0]          data_bits,
  input  logic [1:0]          parity_mode,
  input  logic                two_stop,
  output logic                done,
  output logic                idle,
  output logic                tx
);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [3:0]          idx_q, idx_d;
  logic [3:0]          nbits_q, nbits_d;
  logic                stop_q, stop_d;
  logic [MAX_BITS-1:0] shift_q, shift_d;
  parity_e             pmode_q, pmode_d;
  logic                two_q, two_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;

  logic                load;
  logic                bit_end;
  logic                par_en;
  logic                fifo_full, fifo_empty;
  logic [MAX_BITS-1:0] fifo_rdata;
  logic [3:0]          nbits_new;
  logic [MAX_BITS-1:0] mask_new;

  uart_tx_fifo #(
    .WIDTH (MAX_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .wr_en_i   (enable),
    .wr_data_i (writedata),
    .rd_en_i   (load),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bit_end   = (cnt_q == div_q);
  assign par_en    = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign nbits_new = clamp_bits(data_bits, 4'(MAX_BITS));

  // Parity is fixed at load time over only the bits that will be sent.
  always_comb begin
    mask_new = '0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      mask_new[i] = (i < 32'(nbits_new));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      nbits_q <= MIN_DATA_BITS;
      stop_q  <= 1'b0;
      shift_q <= '0;
      pmode_q <= PAR_NONE;
      two_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      nbits_q <= nbits_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      pmode_q <= pmode_d;
      two_q   <= two_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    nbits_d = nbits_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    pmode_d = pmode_q;
    two_d   = two_q;
    par_d   = par_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: load = !fifo_empty;
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else cnt_d = cnt_q + DIV_W'(1);
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == nbits_q - 4'd1) begin
            state_d = par_en ? ST_PARITY : ST_STOP;
            stop_d  = 1'b0;
          end else idx_d = idx_q + 4'd1;
        end else cnt_d = cnt_q + DIV_W'(1);
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end else cnt_d = cnt_q + DIV_W'(1);
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (two_q && !stop_q) stop_d = 1'b1;
          else if (!fifo_empty) load = 1'b1;
          else state_d = ST_IDLE;
        end else cnt_d = cnt_q + DIV_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // Frame end with data waiting reloads directly into START, no idle gap.
    if (load) begin
      state_d = ST_START;
      cnt_d   = '0;
      idx_d   = '0;
      stop_d  = 1'b0;
      div_d   = divisor;
      nbits_d = nbits_new;
      pmode_d = parity_e'(parity_mode);
      two_d   = two_stop;
      shift_d = fifo_rdata;
      par_d   = (^(fifo_rdata & mask_new)) ^ (parity_e'(parity_mode) == PAR_ODD);
    end
  end

  // Line outputs are registered, adding one cycle of pop-to-line latency.
  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    unique case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_q;
      ST_STOP: begin
        tx_d   = 1'b1;
        done_d = bit_end && (!two_q || stop_q);
      end
      default: tx_d = 1'b1;
    endcase
  end

  assign tx    = tx_q;
  assign done  = done_q;
  assign ready = !fifo_full;
  assign idle  = fifo_empty && (state_q == ST_IDLE) && !done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor checks them cycle by cycle.
module tb_uart_tx_framed;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  writedata = '0;
  logic        enable = 1'b0;
  logic        ready;
  logic [15:0] divisor = 16'd3;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;
  logic        done, idle, tx;

  int cyc = 0;
  int total_cnt = 0;
  int pass_cnt = 0;
  int last_end = 0;

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          per;
    int          exp_start;
    bit          b2b;
    bit          ab;
  } frame_t;

  frame_t sb[$];

  uart_tx_framed #(
    .DIV_W      (16),
    .FIFO_DEPTH (4),
    .MAX_BITS   (9)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .writedata   (writedata),
    .enable      (enable),
    .ready       (ready),
    .divisor     (divisor),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .done        (done),
    .idle        (idle),
    .tx          (tx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, act, exp, cyc);
  endtask

  // Frame builder: n is the already-clamped field length; par 0 none, 1 even, 2 odd.
  function automatic frame_t mk(input logic [8:0] d, input int n, input int par,
                                input bit two, input int per, input int es,
                                input bit b2b, input bit ab);
    frame_t f;
    logic   p = 1'b0;
    f.bits = '0;
    f.n = 0;
    f.bits[f.n] = 1'b0; f.n++;
    for (int i = 0; i < n; i++) begin
      f.bits[f.n] = d[i]; f.n++;
      p ^= d[i];
    end
    if (par != 0) begin
      f.bits[f.n] = (par == 2) ? ~p : p; f.n++;
    end
    f.bits[f.n] = 1'b1; f.n++;
    if (two) begin f.bits[f.n] = 1'b1; f.n++; end
    f.per = per; f.exp_start = es; f.b2b = b2b; f.ab = ab;
    return f;
  endfunction

  task automatic run_frame();
    frame_t f;
    bit aborted = 1'b0;
    bit done_bad = 1'b0;
    bit bad;
    if (sb.size() == 0) begin
      chk("unexpected_frame_tx", int'(tx), 1);
      return;
    end
    f = sb.pop_front();
    if (f.exp_start >= 0) chk("start_cyc", cyc, f.exp_start);
    if (f.b2b) chk("b2b_start_cyc", cyc, last_end + 1);
    for (int b = 0; b < f.n && !aborted; b++) begin
      bad = 1'b0;
      for (int c = 0; c < f.per; c++) begin
        if (b != 0 || c != 0) @(negedge clock);
        if (reset) begin aborted = 1'b1; break; end
        if (tx !== f.bits[b]) bad = 1'b1;
        if (done !== ((b == f.n - 1) && (c == f.per - 1))) done_bad = 1'b1;
      end
      if (!aborted) chk($sformatf("bit%0d_mismatch_flag", b), int'(bad), 0);
    end
    if (aborted) chk("abort_expected", int'(f.ab), 1);
    else begin
      chk("done_pulse_bad", int'(done_bad), 0);
      chk("frame_unexpectedly_completed", int'(f.ab), 0);
      last_end = cyc;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (tx === 1'b0) run_frame();
        else chk("done_outside_frame", int'(done), 0);
      end
    end
  end

  task automatic wr(input logic [8:0] d, output int acc);
    writedata = d;
    enable    = 1'b1;
    @(negedge clock);
    enable    = 1'b0;
    acc       = cyc;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (idle !== 1'b1 && n < bound) begin
      @(negedge clock);
      n++;
    end
    chk("idle_reached", int'(idle), 1);
    repeat (2) @(negedge clock);
  endtask

  initial begin : stim
    int acc;
    int acc0;
    logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (2) @(negedge clock);
    chk("rst_tx", int'(tx), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_idle", int'(idle), 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 8N1, divisor 3, 0xA5
    divisor = 16'd3; data_bits = 4'd8; parity_mode = 2'b00; two_stop = 1'b0;
    wr(9'h0A5, acc);
    sb.push_back(mk(9'h0A5, 8, 0, 1'b0, 4, acc + 2, 1'b0, 1'b0));
    wait_idle(200);

    // 7E2, divisor 1, 0x41
    divisor = 16'd1; data_bits = 4'd7; parity_mode = 2'b01; two_stop = 1'b1;
    wr(9'h041, acc);
    sb.push_back(mk(9'h041, 7, 1, 1'b1, 2, acc + 2, 1'b0, 1'b0));
    wait_idle(200);

    // 7O2: 0x41 and 0x1C1 must produce identical frames
    parity_mode = 2'b10;
    wr(9'h041, acc);
    sb.push_back(mk(9'h041, 7, 2, 1'b1, 2, acc + 2, 1'b0, 1'b0));
    wait_idle(200);
    wr(9'h1C1, acc);
    sb.push_back(mk(9'h041, 7, 2, 1'b1, 2, acc + 2, 1'b0, 1'b0));
    wait_idle(200);

    // data_bits 3 clamps to 5, even parity over 5 ones = 1
    divisor = 16'd2; data_bits = 4'd3; parity_mode = 2'b01; two_stop = 1'b0;
    wr(9'h03F, acc);
    sb.push_back(mk(9'h01F, 5, 1, 1'b0, 3, acc + 2, 1'b0, 1'b0));
    wait_idle(200);

    // data_bits 12 clamps to 9; parity mode 11 means none
    data_bits = 4'd12; parity_mode = 2'b11;
    wr(9'h1FF, acc);
    sb.push_back(mk(9'h1FF, 9, 0, 1'b0, 3, acc + 2, 1'b0, 1'b0));
    wait_idle(200);

    // Six consecutive writes, divisor 0: five accepted, back-to-back frames
    divisor = 16'd0; data_bits = 4'd8; parity_mode = 2'b00; two_stop = 1'b0;
    acc0 = 0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ready_before_write%0d", k), int'(ready), int'(exp_rdy[k]));
      writedata = 9'(8'h30 + k);
      enable    = 1'b1;
      @(negedge clock);
      if (k == 0) begin
        acc0 = cyc;
        sb.push_back(mk(9'h030, 8, 0, 1'b0, 1, acc0 + 2, 1'b0, 1'b0));
      end else if (k < 5) begin
        sb.push_back(mk(9'(8'h30 + k), 8, 0, 1'b0, 1, -1, 1'b1, 1'b0));
      end
    end
    enable = 1'b0;
    wait_idle(400);
    chk("idle_after_burst", int'(idle), 1);

    // Config change mid-frame applies only to the following frame
    divisor = 16'd3; data_bits = 4'd8; parity_mode = 2'b00; two_stop = 1'b0;
    wr(9'h055, acc);
    sb.push_back(mk(9'h055, 8, 0, 1'b0, 4, acc + 2, 1'b0, 1'b0));
    repeat (6) @(negedge clock);
    divisor = 16'd7; data_bits = 4'd7; parity_mode = 2'b01;
    wr(9'h00F, acc);
    sb.push_back(mk(9'h00F, 7, 1, 1'b0, 8, -1, 1'b1, 1'b0));
    wait_idle(600);

    // Reset during DATA with two entries queued
    divisor = 16'd3; data_bits = 4'd8; parity_mode = 2'b00; two_stop = 1'b0;
    writedata = 9'h0C3; enable = 1'b1;
    @(negedge clock);
    acc0 = cyc;
    sb.push_back(mk(9'h0C3, 8, 0, 1'b0, 4, acc0 + 2, 1'b0, 1'b1));
    writedata = 9'h011;
    @(negedge clock);
    writedata = 9'h022;
    @(negedge clock);
    enable = 1'b0;
    while (cyc < acc0 + 15) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_done", int'(done), 0);
    chk("midrst_idle", int'(idle), 1);
    chk("midrst_ready", int'(ready), 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (80) @(negedge clock);
    chk("post_reset_idle", int'(idle), 1);
    chk("post_reset_tx", int'(tx), 1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
- REQ-001 The block SHALL have parameter DIV_W, default 16, meaning the width of the baud divisor.
- REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, ≥2), meaning the number of transmit FIFO entries.
- REQ-003 The block SHALL have parameter MAX_BITS, default 9, meaning the widest supported data field.
- REQ-004 The block SHALL have port `clock`, input, 1 bit: the single clock.
- REQ-005 The block SHALL have port `reset`, input, 1 bit: reset, asynchronous and active-high.
- REQ-006 The block SHALL have port `writedata`, input, MAX_BITS bits: the character to queue, LSB-aligned.
- REQ-007 The block SHALL have port `enable`, input, 1 bit: write strobe.
- REQ-008 The block SHALL have port `ready`, output, 1 bit: FIFO not full.
- REQ-009 The block SHALL have port `divisor`, input, DIV_W bits: bit period is divisor+1 clock cycles.
- REQ-010 The block SHALL have port `data_bits`, input, 4 bits: data field length.
- REQ-011 The block SHALL have port `parity_mode`, input, 2 bits: 00 none, 01 even, 10 odd, 11 none.
- REQ-012 The block SHALL have port `two_stop`, input, 1 bit: 0 = one stop bit, 1 = two stop bits.
- REQ-013 The block SHALL have port `done`, output, 1 bit: one-cycle pulse at frame end.
- REQ-014 The block SHALL have port `idle`, output, 1 bit: FIFO empty and no frame in flight.
- REQ-015 The block SHALL have port `tx`, output, 1 bit: serial line, idle high.

Function
- REQ-016 A write SHALL be accepted on a rising edge where enable=1 and ready=1; enable while ready=0 SHALL be ignored and the FIFO left unchanged.
- REQ-017 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP.
- REQ-018 In IDLE with the FIFO non-empty, the block SHALL pop one entry, latch divisor, data_bits, parity_mode and two_stop, and enter START.
- REQ-019 In an empty, idle block, tx SHALL fall exactly 2 rising edges after the accepting edge.
- REQ-020 Each bit (start, data, parity, stop) SHALL hold tx for exactly latched divisor+1 cycles; divisor=0 gives 1 cycle per bit.
- REQ-021 START SHALL drive tx=0.
- REQ-022 DATA SHALL send latched data_bits bits, LSB first.
- REQ-023 data_bits values below 5 SHALL be treated as 5, and values above MAX_BITS as MAX_BITS.
- REQ-024 PARITY SHALL be entered only when the latched mode is even or odd.
- REQ-025 The even parity bit SHALL be the XOR of the transmitted data bits; the odd parity bit SHALL be its inverse.
- REQ-026 Bits above the latched data_bits SHALL NOT affect the parity bit.
- REQ-027 STOP SHALL drive tx=1 for one or two bit periods per latched two_stop.
- REQ-028 done SHALL pulse for one cycle in the last cycle of the final stop bit.
- REQ-029 If the FIFO is non-empty at frame end, the next START SHALL begin on the following cycle with no extra idle cycle; otherwise the block SHALL return to IDLE.
- REQ-030 Configuration changes mid-frame SHALL NOT affect the frame in flight.
- REQ-031 A write and a pop in the same cycle with the FIFO full SHALL be allowed: ready reflects full before the pop, so that write is refused.
- REQ-032 A write and a pop in the same cycle with the FIFO partially filled SHALL both succeed, leaving the occupancy unchanged.
- REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
- REQ-034 The bit counter SHALL be DIV_W bits wide and SHALL never overflow.

Reset
- REQ-035 Asserting reset SHALL immediately set tx=1, done=0, ready=1 and idle=1.
- REQ-036 Asserting reset SHALL empty the FIFO, zero all counters and force the state to IDLE.
- REQ-037 Reset mid-frame SHALL abort the frame with no done pulse and discard the queued entries.

Structure
- REQ-038 A shared package uart_pkg SHALL hold the state encoding, the parity_mode encodings, and the minimum data-bit constant (5).
- REQ-039 The FIFO SHALL be a sub-module, uart_tx_fifo, parameterised by width and depth, with full/empty flags.

Verification
- REQ-040 divisor=3, 8N1, write 0xA5 -> tx: 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; 40 cycles total; done pulses at cycle 40.
- REQ-041 divisor=1, 7 bits, even parity, two_stop=1, write 0x41 -> data 1,0,0,0,0,0,1, parity 0, two stop bits; 11 bits × 2 cycles.
- REQ-042 Same as REQ-041 with odd parity -> parity bit 1; writedata 0x1C1 with 7 bits -> identical frame (upper bits ignored).
- REQ-043 FIFO_DEPTH=4, divisor=0, write 6 words on consecutive cycles -> 5 accepted (1 popped plus 4 queued), 6th refused with ready=0; 5 back-to-back frames with no idle gap; 5 done pulses; idle=1 afterwards.
- REQ-044 Assert reset mid-DATA with 2 words queued -> tx=1 same cycle, no done pulse, idle=1; no further frames after reset release.
- REQ-045 Change divisor from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
